// File: rtl/convex_point_sorter.sv
// Counter-clockwise vertex sorter: ranks N anchor-relative points by cross-product counts and streams them out.
// Optional feature: define POLY_AREA_EN to build the twice-area accumulator driving out_area2.
//
// state   | meaning
// S_LOAD  | accept N points, in_ready high
// S_VEC   | form anchor-relative vectors
// S_CROSS | N*N pairwise cross products, count clockwise/tied neighbours
// S_RANK  | scatter indices into output order
// S_EMIT  | stream sorted points with valid/ready
module convex_point_sorter #(
   parameter int N = 6,
   parameter int W = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [W-1:0]               in_x,
   input  logic [W-1:0]               in_y,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [W-1:0]               out_x,
   output logic [W-1:0]               out_y,
   output logic [$clog2(N)-1:0]       out_idx,
   output logic                       out_last,
   output logic                       busy,
   output logic [2*W+2+$clog2(N):0]   out_area2
);

   localparam int IW = $clog2(N);
   localparam int CW = $clog2(2*N+1);
   localparam int DW = W+1;
   localparam int PW = 2*W+3;
   localparam int AW = 2*W+3+IW;
   localparam logic [IW-1:0] LAST = IW'(N-1);

   typedef enum logic [2:0] {S_LOAD, S_VEC, S_CROSS, S_RANK, S_EMIT} state_t;
   state_t state, state_nx;

   logic [W-1:0]          px    [N];
   logic [W-1:0]          py    [N];
   logic signed [DW-1:0]  dx    [N];
   logic signed [DW-1:0]  dy    [N];
   logic [CW-1:0]         neg   [N];
   logic [CW-1:0]         tie   [N];
   logic [IW-1:0]         order [N];
   logic [IW-1:0]         order_c [N];
   logic [IW-1:0]         cnt, k, j, e, e_nx;
   logic                  accept_in, accept_out;
   logic signed [PW-1:0]  c_kj;

   function automatic logic signed [PW-1:0] cross2(input logic signed [DW-1:0] ax, ay, bx, by);
      return PW'(ax) * PW'(by) - PW'(bx) * PW'(ay);
   endfunction

   assign accept_in  = in_valid && in_ready;
   assign accept_out = out_valid && out_ready;
   assign c_kj       = cross2(dx[k], dy[k], dx[j], dy[j]);
   assign e_nx       = (e == LAST) ? '0 : e + 1'b1;

   // Point k lands after the anchor, past every point clockwise of it and every earlier tie.
   always_comb begin
      for (int p = 0; p < N; p++) order_c[p] = '0;
      for (int p = 1; p < N; p++)
         for (int m = 1; m < N; m++)
            if (CW'(1) + neg[m] + tie[m] == CW'(p)) order_c[p] = IW'(m);
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_LOAD:  if (accept_in && cnt == LAST) state_nx = S_VEC;
         S_VEC:   state_nx = S_CROSS;
         S_CROSS: if (k == LAST && j == LAST) state_nx = S_RANK;
         S_RANK:  state_nx = S_EMIT;
         S_EMIT:  if (accept_out && e == LAST) state_nx = S_LOAD;
         default: state_nx = S_LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_LOAD;
      else       state <= state_nx;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            px[i] <= '0;  py[i] <= '0;  dx[i] <= '0;  dy[i] <= '0;
            neg[i] <= '0; tie[i] <= '0; order[i] <= '0;
         end
         cnt <= '0; k <= '0; j <= '0; e <= '0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_x     <= '0;
         out_y     <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
      end else begin
         in_ready  <= (state_nx == S_LOAD);
         busy      <= (state_nx != S_LOAD);
         out_valid <= (state_nx == S_EMIT);
         case (state)
            S_LOAD: if (accept_in) begin
               px[cnt] <= in_x;
               py[cnt] <= in_y;
               cnt     <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
            S_VEC: for (int i = 0; i < N; i++) begin
               dx[i] <= $signed({1'b0, px[i]}) - $signed({1'b0, px[0]});
               dy[i] <= $signed({1'b0, py[i]}) - $signed({1'b0, py[0]});
            end
            S_CROSS: begin
               if (c_kj[PW-1])                                tie[k] <= tie[k];
               if (c_kj[PW-1])                                neg[k] <= neg[k] + 1'b1;
               else if (c_kj == '0 && j != '0 && j < k)       tie[k] <= tie[k] + 1'b1;
               if (j == LAST) begin
                  j <= '0;
                  k <= (k == LAST) ? '0 : k + 1'b1;
               end else begin
                  j <= j + 1'b1;
               end
            end
            S_RANK: begin
               for (int i = 0; i < N; i++) order[i] <= order_c[i];
               out_x    <= px[0];
               out_y    <= py[0];
               out_idx  <= '0;
               out_last <= 1'b0;
               e        <= '0;
            end
            S_EMIT: if (accept_out) begin
               if (e == LAST) begin
                  for (int i = 0; i < N; i++) begin
                     px[i] <= '0;  py[i] <= '0;  dx[i] <= '0;  dy[i] <= '0;
                     neg[i] <= '0; tie[i] <= '0; order[i] <= '0;
                  end
                  cnt <= '0; k <= '0; j <= '0; e <= '0;
                  out_last <= 1'b0;
               end else begin
                  e        <= e_nx;
                  out_x    <= px[order[e_nx]];
                  out_y    <= py[order[e_nx]];
                  out_idx  <= order[e_nx];
                  out_last <= (e_nx == LAST);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef POLY_AREA_EN
   logic signed [AW-1:0] acc, area_q;
   logic signed [PW-1:0] c_emit;

   assign c_emit = cross2(dx[order[e]], dy[order[e]], dx[order[e_nx]], dy[order[e_nx]]);

   // The closing edge back to the anchor contributes nothing, so the total is latched one beat early.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc    <= '0;
         area_q <= '0;
      end else if (state == S_RANK) begin
         acc <= '0;
      end else if (state == S_EMIT && accept_out) begin
         acc <= acc + AW'(c_emit);
         if (e_nx == LAST) area_q <= acc + AW'(c_emit);
      end
   end

   assign out_area2 = area_q;
`else
   assign out_area2 = '0;
`endif

endmodule

// File: tb/tb_convex_point_sorter.sv
// Self-checking bench for convex_point_sorter: directed table, stall/reset/back-to-back sequences,
// small-N instances and randomized convex frames against an insertion-sort + shoelace model.
module tb_convex_point_sorter;
   localparam int N = 6;
`ifdef POLY_AREA_EN
   localparam bit AREA_ON = 1'b1;
`else
   localparam bit AREA_ON = 1'b0;
`endif

   logic clk = 1'b0, reset = 1'b0;
   logic in_valid = 1'b0, out_ready = 1'b1;
   logic [7:0] in_x = '0, in_y = '0;
   logic in_ready, out_valid, out_last, busy;
   logic [7:0] out_x, out_y;
   logic [2:0] out_idx;
   logic [21:0] out_area2;

   convex_point_sorter #(.N(6), .W(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y), .out_idx(out_idx), .out_last(out_last),
      .busy(busy), .out_area2(out_area2));

   // small instances share a stimulus port, selected by sel
   logic sel = 1'b0, s_valid = 1'b0, s_ordy = 1'b1;
   logic [7:0] s_x = '0, s_y = '0;
   logic r4, v4, l4, b4, r3, v3, l3, b3;
   logic [7:0] x4, y4;
   logic [3:0] x3, y3;
   logic [1:0] i4, i3;
   logic [20:0] a4;
   logic [12:0] a3;

   convex_point_sorter #(.N(4), .W(8)) dut4 (
      .clk(clk), .reset(reset), .in_valid(s_valid && !sel), .in_x(s_x), .in_y(s_y),
      .in_ready(r4), .out_valid(v4), .out_ready(s_ordy), .out_x(x4), .out_y(y4),
      .out_idx(i4), .out_last(l4), .busy(b4), .out_area2(a4));

   convex_point_sorter #(.N(3), .W(4)) dut3 (
      .clk(clk), .reset(reset), .in_valid(s_valid && sel), .in_x(s_x[3:0]), .in_y(s_y[3:0]),
      .in_ready(r3), .out_valid(v3), .out_ready(s_ordy), .out_x(x3), .out_y(y3),
      .out_idx(i3), .out_last(l3), .busy(b3), .out_area2(a3));

   logic s_rdy, s_ov, s_last, s_busy;
   logic [7:0] s_ox, s_oy;
   logic [1:0] s_idx;
   logic [20:0] s_area;
   assign s_rdy  = sel ? r3 : r4;
   assign s_ov   = sel ? v3 : v4;
   assign s_last = sel ? l3 : l4;
   assign s_busy = sel ? b3 : b4;
   assign s_ox   = sel ? {4'b0, x3} : x4;
   assign s_oy   = sel ? {4'b0, y3} : y4;
   assign s_idx  = sel ? i3 : i4;
   assign s_area = sel ? 21'(a3) : a4;

   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0, bad = 0;
   int fx[16], fy[16], ex_idx[16], m_idx[16];
   longint ex_area, m_area;
   int c0;
   int cx[16] = '{100, 92, 71, 38, 0, -38, -71, -92, -100, -92, -71, -38, 0, 38, 71, 92};
   int cy[16] = '{0, 38, 71, 92, 100, 92, 71, 38, 0, -38, -71, -92, -100, -92, -71, -38};

   typedef struct packed {
      logic [5:0][7:0] x;
      logic [5:0][7:0] y;
      logic [5:0][2:0] idx;
      logic [31:0]     area;
      logic [1:0]      mode;
      logic            junk;
      logic            lat;
   } vec_t;
   vec_t tv[4];

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [5:0][7:0] p8(input int a0, a1, a2, a3, a4, a5);
      logic [5:0][7:0] r;
      r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3); r[4] = 8'(a4); r[5] = 8'(a5);
      return r;
   endfunction

   function automatic logic [5:0][2:0] p3(input int a0, a1, a2, a3, a4, a5);
      logic [5:0][2:0] r;
      r[0] = 3'(a0); r[1] = 3'(a1); r[2] = 3'(a2); r[3] = 3'(a3); r[4] = 3'(a4); r[5] = 3'(a5);
      return r;
   endfunction

   function automatic bit ccw_before(input int xs[16], input int ys[16], input int a, input int b);
      longint ax, ay, bx, by;
      ax = xs[a] - xs[0]; ay = ys[a] - ys[0];
      bx = xs[b] - xs[0]; by = ys[b] - ys[0];
      return (ax * by - bx * ay) > 0;
   endfunction

   // reference: angular insertion sort around the anchor, shoelace area on absolute coordinates
   task automatic model(input int n, input int xs[16], input int ys[16]);
      int q[$];
      int p, a, b;
      q = {};
      for (int k = 1; k < n; k++) begin
         p = 0;
         while (p < q.size() && !ccw_before(xs, ys, k, q[p])) p++;
         q.insert(p, k);
      end
      m_idx[0] = 0;
      for (int i = 0; i < n - 1; i++) m_idx[i + 1] = q[i];
      m_area = 0;
      for (int i = 0; i < n; i++) begin
         a = m_idx[i];
         b = m_idx[(i + 1) % n];
         m_area += longint'(xs[a]) * ys[b] - longint'(xs[b]) * ys[a];
      end
   endtask

   task automatic load_main();
      int w;
      for (int i = 0; i < N; i++) begin
         w = 0;
         while (!in_ready && w < 100) begin @(negedge clk); w++; end
         chk("load_in_ready", in_ready, 1);
         if (i == 0) c0 = cyc;
         in_valid = 1'b1; in_x = 8'(fx[i]); in_y = 8'(fy[i]);
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic collect(input int mode, input bit junk, input bit chk_lat);
      int e, waits, stall;
      bit go, first;
      e = 0; waits = 0; stall = 3; first = 1'b1;
      while (e < N && waits < 400) begin
         if (junk) begin
            in_valid = 1'b1; in_x = 8'($urandom); in_y = 8'($urandom);
            chk("busy_in_ready", in_ready, 0);
         end
         if (out_valid) begin
            if (first && chk_lat) chk("latency", cyc - c0, N + 1 + N * N + 1);
            first = 1'b0;
            chk("beat_idx", out_idx, ex_idx[e]);
            chk("beat_x", out_x, fx[ex_idx[e]]);
            chk("beat_y", out_y, fy[ex_idx[e]]);
            chk("beat_last", out_last, (e == N - 1));
            chk("beat_busy", busy, 1);
            if (e == N - 1) chk("area2", out_area2, AREA_ON ? ex_area : 0);
            go = 1'b1;
            if (mode == 1 && e == 2 && stall > 0) begin go = 1'b0; stall--; end
            if (mode == 2) go = ($urandom_range(0, 3) != 0);
            out_ready = go;
            if (go) e++;
         end
         @(negedge clk);
         waits++;
      end
      chk("frame_beats", e, N);
      in_valid = 1'b0; out_ready = 1'b1;
      chk("idle_in_ready", in_ready, 1);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_busy", busy, 0);
   endtask

   task automatic run_small(input bit s, input int n, input longint exp_area);
      int w, e;
      sel = s; s_ordy = 1'b1;
      for (int i = 0; i < n; i++) begin
         w = 0;
         while (!s_rdy && w < 100) begin @(negedge clk); w++; end
         s_valid = 1'b1; s_x = 8'(fx[i]); s_y = 8'(fy[i]);
         @(negedge clk);
      end
      s_valid = 1'b0;
      e = 0; w = 0;
      while (e < n && w < 400) begin
         if (s_ov) begin
            chk("small_idx", s_idx, ex_idx[e]);
            chk("small_x", s_ox, fx[ex_idx[e]]);
            chk("small_y", s_oy, fy[ex_idx[e]]);
            chk("small_last", s_last, (e == n - 1));
            chk("small_busy", s_busy, 1);
            if (e == n - 1) chk("small_area2", s_area, AREA_ON ? exp_area : 0);
            e++;
         end
         @(negedge clk);
         w++;
      end
      chk("small_beats", e, n);
      chk("small_idle_ready", s_rdy, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      int perm[16];
      int t, r, ox, oy;
      tv[0] = '{x: p8(10, 40, 5, 50, 15, 60), y: p8(10, 70, 30, 10, 50, 40),
                idx: p3(0, 3, 5, 1, 4, 2), area: 4500, mode: 0, junk: 0, lat: 1};
      tv[1] = tv[0]; tv[1].mode = 1; tv[1].lat = 0;
      tv[2] = tv[0]; tv[2].junk = 1; tv[2].lat = 0;
      tv[3] = '{x: p8(50, 10, 60, 5, 40, 15), y: p8(10, 10, 40, 30, 70, 50),
                idx: p3(0, 2, 4, 5, 3, 1), area: 4500, mode: 0, junk: 0, lat: 0};

      #2 reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_x", out_x, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_area2", out_area2, 0);
      reset = 1'b0;
      @(negedge clk);

      for (t = 0; t < 4; t++) begin
         for (int i = 0; i < N; i++) begin
            fx[i] = tv[t].x[i]; fy[i] = tv[t].y[i]; ex_idx[i] = tv[t].idx[i];
         end
         ex_area = tv[t].area;
         load_main();
         collect(tv[t].mode, tv[t].junk, tv[t].lat);
      end

      // reset in the middle of CROSS, then a clean frame
      load_main();
      repeat (10) @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      reset = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_in_ready", in_ready, 1);
      @(negedge clk);
      reset = 1'b0;
      load_main();
      collect(0, 1'b0, 1'b1);

      // full-scale N=4 and minimal N=3
      fx[0] = 0; fy[0] = 0; fx[1] = 255; fy[1] = 255; fx[2] = 255; fy[2] = 0; fx[3] = 0; fy[3] = 255;
      ex_idx[0] = 0; ex_idx[1] = 2; ex_idx[2] = 1; ex_idx[3] = 3;
      run_small(1'b0, 4, 130050);
      fx[0] = 0; fy[0] = 0; fx[1] = 0; fy[1] = 15; fx[2] = 15; fy[2] = 0;
      ex_idx[0] = 0; ex_idx[1] = 2; ex_idx[2] = 1;
      run_small(1'b1, 3, 225);

      // randomized convex frames drawn from a strictly convex 16-point ring
      for (r = 0; r < 25; r++) begin
         int tmp, sw;
         for (int i = 0; i < 16; i++) perm[i] = i;
         for (int i = 15; i > 0; i--) begin
            sw = $urandom_range(0, i);
            tmp = perm[i]; perm[i] = perm[sw]; perm[sw] = tmp;
         end
         ox = $urandom_range(0, 40) - 20;
         oy = $urandom_range(0, 40) - 20;
         for (int i = 0; i < N; i++) begin
            fx[i] = 128 + ox + cx[perm[i]];
            fy[i] = 128 + oy + cy[perm[i]];
         end
         model(N, fx, fy);
         for (int i = 0; i < N; i++) ex_idx[i] = m_idx[i];
         ex_area = m_area;
         load_main();
         collect(2, r[0], 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/convex_point_sorter.md
# convex_point_sorter

Parametrised polygon-vertex sorter. Accepts N points of unsigned W-bit coordinates and orders them counter-clockwise, starting from the first point received (the anchor). Ordering uses pairwise cross products of anchor-relative vectors, then the sorted points stream out with a valid/ready handshake. It sits between the point-capture front end and the geometry post-processing stage, and generalises the fixed 6-point, 8-bit sorter.

## Interface
- N, 6, number of points per frame, 3..16
- W, 8, coordinate width, 4..16
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  input point valid
- in_x, in_y  in  W  input coordinates, unsigned
- in_ready  out  1  high only in LOAD
- out_valid  out  1  output point valid
- out_ready  in  1  downstream accepts point
- out_x, out_y  out  W  sorted point coordinates
- out_idx  out  clog2(N)  input index of the emitted point
- out_last  out  1  high on the N-th output beat
- busy  out  1  high in VEC/CROSS/RANK/EMIT
- out_area2  out  2W+3+clog2(N)  twice the polygon area (POLY_AREA_EN only)

## Operation
- Reset values: in_ready=1, all other outputs 0, state=LOAD, all counters and arrays 0.
- LOAD: each cycle with in_valid&&in_ready stores point[cnt] and increments cnt. After the N-th accept, the next state is VEC.
- VEC (1 cycle): dx[k]=x[k]-x[0] and dy[k]=y[k]-y[0], both signed W+1 bits. dx[0]=dy[0]=0.
- CROSS (N*N cycles): k outer loop, j inner loop, both 0..N-1. c=dx[k]*dy[j]-dx[j]*dy[k], signed 2W+3 bits, no truncation.
  - c<0 increments neg[k].
  - c==0 with 1<=j<k increments tie[k].
  - At k=j=N-1 the next state is RANK.
- RANK (1 cycle): order[0]=0. For each k>=1, order[1+neg[k]+tie[k]]=k.
- EMIT: beat e presents point[order[e]], out_idx=order[e], out_last=(e==N-1). Outputs hold while out_ready=0. A beat advances on out_valid&&out_ready. After the last beat is accepted the next state is LOAD, with arrays, neg, tie and counters cleared.
- Input contract: points form a convex polygon with no three points collinear, and point 0 is a hull vertex. If the contract is violated, the output order is unspecified, but the block still emits exactly N beats and returns to LOAD.
- in_valid outside LOAD is ignored. No points are lost across frames; a new frame is accepted from the cycle after out_last is accepted.

## Timing
- Minimum frame latency, from the first in_valid accept to the first out_valid: N+1+N*N+1 cycles after the N-th accept the anchor is already presented (N accepts, VEC 1, CROSS N*N, RANK 1).
- out_valid first rises on the cycle after RANK. All outputs are registered.
- in_ready rises the cycle after the final output handshake.
- Reset asserted in any state returns the block to LOAD asynchronously, with all outputs at reset values. The partial frame is discarded.

## Configuration
- POLY_AREA_EN defined:
  - During EMIT, each accepted beat e adds cross(v[order[e]], v[order[(e+1)%N]]) to an accumulator.
  - out_area2 presents the full sum while out_valid&&out_last. It holds until the next frame's first output beat, and is cleared by reset.
  - The sum is complete before the last beat because the anchor vector is zero.
- POLY_AREA_EN undefined: the accumulator is not built and out_area2 is tied to 0.

## Test plan
- N=6, W=8. Input (10,10),(40,70),(5,30),(50,10),(15,50),(60,40), out_ready=1 -> out_idx 0,3,5,1,4,2. Points (10,10),(50,10),(60,40),(40,70),(15,50),(5,30). out_last on beat 6. out_area2=4500 with the macro, 0 without.
- Same frame with out_ready dropped for 3 cycles at beat 2 -> out_x/out_y/out_idx stable at (60,40)/5 during the stall. Sequence unchanged. Total beats 6.
- Reset pulsed during CROSS -> same cycle out_valid=0, busy=0, in_ready=1. A following full frame produces correct order and out_area2.
- N=4, W=8. Input (0,0),(255,255),(255,0),(0,255) -> out_idx 0,2,1,3, out_area2=130050. No overflow at full-scale coordinates.
- in_valid held high with junk data during busy, then a second frame sent back-to-back -> junk ignored. Second frame sorted correctly. in_ready=0 throughout busy.
- N=3, W=4. Input (0,0),(0,15),(15,0) -> out_idx 0,2,1, out_area2=225.
